data_memory: RTL and testbench



---
 rtl/data_mem_pkg.sv | 22 ++
 rtl/data_memory_if.sv | 31 +++
 rtl/data_mem_load_ext.sv | 25 ++
 rtl/data_memory.sv | 63 ++++++
 tb/tb_data_memory.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: size encodings, widths and the
// helper that turns an access size into a 4-lane byte mask.
package data_mem_pkg;

    localparam int unsigned DM_ADDR_BITS   = 12;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Byte lanes touched by an access; encoding 2'b11 behaves like a word.
    function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage load/store bus between the core (master) and the data memory
// (slave).
//   memwrite   : store enable, sampled on the rising clock edge
//   memread    : load enable, gates read_data
//   sign_ext   : 1 = sign-extend sub-word loads, 0 = zero-extend
//   address    : byte address (only the low address bits are decoded)
//   write_data : store data, low 8/16/32 bits used per byte_size
//   byte_size  : 00 byte, 01 half, 10 word, 11 word
//   read_data  : combinational load result
interface data_memory_if;
    import data_mem_pkg::*;

    logic                  memwrite;
    logic                  memread;
    logic                  sign_ext;
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [1:0]            byte_size;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output memwrite, memread, sign_ext, address, write_data, byte_size,
        input  read_data
    );

    modport slave (
        input  memwrite, memread, sign_ext, address, write_data, byte_size,
        output read_data
    );

endinterface

// File: rtl/data_mem_load_ext.sv
// Combinational load extractor: picks the byte/half/word out of four raw
// little-endian bytes and sign- or zero-extends it to 32 bits.
//   raw_i       : {mem[A+3], mem[A+2], mem[A+1], mem[A]}
//   byte_size_i : access size encoding
//   sign_ext_i  : sign-extend sub-word results when set
//   data_o      : extended load value
module data_mem_load_ext
    import data_mem_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] raw_i,
    input  logic [1:0]            byte_size_i,
    input  logic                  sign_ext_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (byte_size_i)
            SIZE_BYTE: data_o = {{24{sign_ext_i & raw_i[7]}}, raw_i[7:0]};
            SIZE_HALF: data_o = {{16{sign_ext_i & raw_i[15]}}, raw_i[15:0]};
            default:   data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the MEM stage.
// Synchronous stores (byte/half/word, unaligned, wrapping at the top of the
// array), combinational loads with sub-word extension.
//   clock : rising-edge clock
//   reset : synchronous active-high clear of every byte (blocks stores)
//   mem   : load/store bus (slave side)
module data_memory
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DM_ADDR_BITS
) (
    input  logic         clock,
    input  logic         reset,
    data_memory_if.slave mem
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [7:0]                mem_q [DEPTH];
    logic [ADDR_BITS-1:0]      base_addr;
    logic [ADDR_BITS-1:0]      byte_addr [BYTES_PER_WORD];
    logic [BYTES_PER_WORD-1:0] lane_en;
    logic [DATA_WIDTH-1:0]     raw_word;
    logic [DATA_WIDTH-1:0]     ext_word;
    logic                      unused_addr_hi;

    // Address bits above the decoded range are ignored (aliasing accepted).
    assign base_addr      = mem.address[ADDR_BITS-1:0];
    assign unused_addr_hi = ^mem.address[DATA_WIDTH-1:ADDR_BITS];
    assign lane_en        = lane_mask(mem.byte_size);

    // Lane k addresses A+k; the ADDR_BITS-wide sum wraps past the top byte.
    for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
        assign byte_addr[k]       = base_addr + ADDR_BITS'(k);
        assign raw_word[8*k +: 8] = mem_q[byte_addr[k]];
    end

    // Byte array: reset clears everything and wins over a concurrent store.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem.memwrite) begin
            for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
                if (lane_en[k]) begin
                    mem_q[byte_addr[k]] <= mem.write_data[8*k +: 8];
                end
            end
        end
    end

    data_mem_load_ext u_load_ext (
        .raw_i       (raw_word),
        .byte_size_i (mem.byte_size),
        .sign_ext_i  (mem.sign_ext),
        .data_o      (ext_word)
    );

    // Loads show pre-edge contents; no forwarding from a same-cycle store.
    assign mem.read_data = mem.memread ? ext_word : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, hand-written
// corner sequences, and randomized traffic against a byte-array model.
module tb_data_memory;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    data_memory_if bus ();

    data_memory dut (
        .clock (clock),
        .reset (reset),
        .mem   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] model [4096];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    function automatic int midx(input logic [31:0] a, input int i);
        return int'((a + 32'(i)) % 32'd4096);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: assemble bytes arithmetically, then sign-extend by
    // subtracting 2**(8n) when the top bit of the n-byte value is set.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sx, input logic rd);
        logic [63:0] v;
        int n;
        if (!rd) return 32'h0;
        n = nbytes(sz);
        v = 64'h0;
        for (int i = 0; i < n; i++) v = v + (64'(model[midx(a, i)]) << (8 * i));
        if (sx && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.memwrite   = 1'b0;
        bus.memread    = 1'b0;
        bus.sign_ext   = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        bus.byte_size  = 2'b10;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clock);
        bus.memwrite   = 1'b1;
        bus.memread    = 1'b0;
        bus.address    = a;
        bus.write_data = d;
        bus.byte_size  = sz;
        @(posedge clock);
        for (int i = 0; i < nbytes(sz); i++) model[midx(a, i)] = 8'((d >> (8 * i)) & 32'hFF);
        #1 bus.memwrite = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [1:0] sz,
                              input logic sx, input logic [31:0] exp);
        @(negedge clock);
        bus.memwrite  = 1'b0;
        bus.memread   = 1'b1;
        bus.address   = a;
        bus.byte_size = sz;
        bus.sign_ext  = sx;
        #1 check(name, bus.read_data, exp);
    endtask

    // Reset pulse with a store attempt that must be blocked.
    task automatic pulse_reset();
        @(negedge clock);
        reset          = 1'b1;
        bus.memwrite   = 1'b1;
        bus.address    = 32'h0;
        bus.write_data = 32'h55555555;
        bus.byte_size  = 2'b10;
        @(posedge clock);
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;
        #1;
        reset        = 1'b0;
        bus.memwrite = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic        sx;

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;
        #1 reset = 1'b0;

        // Post-reset state
        load_check("rst_lw0",    32'h0,   2'b10, 1'b0, 32'h0);
        load_check("rst_lw_mid", 32'h7F0, 2'b10, 1'b0, 32'h0);
        load_check("rst_lb_top", 32'hFFF, 2'b00, 1'b1, 32'h0);

        // Setup stores for the vector table
        store(32'd0,  32'hDEADBEEF, 2'b10);
        store(32'd8,  32'h00001234, 2'b01);
        store(32'd10, 32'h000080AA, 2'b01);
        store(32'd16, 32'h11223344, 2'b10);
        store(32'd17, 32'h000000FF, 2'b00);

        vecs.push_back('{"lw_deadbeef", 32'd0,  2'b10, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{"lbu_b0",      32'd0,  2'b00, 1'b0, 32'h000000EF});
        vecs.push_back('{"lb_a3_sx",    32'd3,  2'b00, 1'b1, 32'hFFFFFFDE});
        vecs.push_back('{"lbu_a3",      32'd3,  2'b00, 1'b0, 32'h000000DE});
        vecs.push_back('{"lb_a0_sx",    32'd0,  2'b00, 1'b1, 32'hFFFFFFEF});
        vecs.push_back('{"lw_half_mrg", 32'd8,  2'b10, 1'b0, 32'h80AA1234});
        vecs.push_back('{"lh_a10_sx",   32'd10, 2'b01, 1'b1, 32'hFFFF80AA});
        vecs.push_back('{"lhu_a10",     32'd10, 2'b01, 1'b0, 32'h000080AA});
        vecs.push_back('{"lw_sb_merge", 32'd16, 2'b10, 1'b0, 32'h1122FF44});
        vecs.push_back('{"lw_size11",   32'd16, 2'b11, 1'b1, 32'h1122FF44});
        vecs.push_back('{"lb_pos_sx",   32'd16, 2'b00, 1'b1, 32'h00000044});
        vecs.push_back('{"lh_unalign",  32'd1,  2'b01, 1'b1, 32'hFFFFADBE});
        vecs.push_back('{"lw_alias",    32'h8000_1010, 2'b10, 1'b0, 32'h1122FF44});

        foreach (vecs[i]) load_check(vecs[i].name, vecs[i].addr, vecs[i].size, vecs[i].sext, vecs[i].exp);

        // Wrap past the top of the array
        store(32'hFFE, 32'hCAFEBABE, 2'b10);
        load_check("lw_wrap",      32'hFFE, 2'b10, 1'b0, 32'hCAFEBABE);
        load_check("lh_wrap_low",  32'h0,   2'b01, 1'b0, 32'h0000CAFE);
        load_check("lw0_after",    32'h0,   2'b10, 1'b0, 32'hDEADCAFE);
        load_check("lw_wrap_alias", 32'h0001_3FFE, 2'b10, 1'b0, 32'hCAFEBABE);

        // memread gating
        @(negedge clock);
        bus.memread   = 1'b0;
        bus.address   = 32'd16;
        bus.byte_size = 2'b10;
        #1 check("rd_gated", bus.read_data, 32'h0);

        // Simultaneous read + write: old data before the edge, new after
        store(32'd40, 32'hAAAA5555, 2'b10);
        @(negedge clock);
        bus.memread    = 1'b1;
        bus.memwrite   = 1'b1;
        bus.address    = 32'd40;
        bus.byte_size  = 2'b10;
        bus.write_data = 32'h01020304;
        #1 check("rw_pre_edge", bus.read_data, 32'hAAAA5555);
        @(posedge clock);
        for (int i = 0; i < 4; i++) model[40 + i] = 8'(i == 0 ? 4 : i == 1 ? 3 : i == 2 ? 2 : 1);
        #1;
        bus.memwrite = 1'b0;
        check("rw_post_edge", bus.read_data, 32'h01020304);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            a  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63)) | 32'hFC0 * 32'($urandom_range(0, 1));
            d  = $urandom();
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                store(a, d, sz);
            end else begin
                logic rd;
                rd = ($urandom_range(0, 7) != 0);
                @(negedge clock);
                bus.memwrite  = 1'b0;
                bus.memread   = rd;
                bus.address   = a;
                bus.byte_size = sz;
                bus.sign_ext  = sx;
                #1 check("rand_load", bus.read_data, model_load(a, sz, sx, rd));
            end
        end

        // Reset with a concurrent store: everything reads back zero
        pulse_reset();
        load_check("rst2_lw0",   32'd0,   2'b10, 1'b0, 32'h0);
        load_check("rst2_lw16",  32'd16,  2'b10, 1'b0, 32'h0);
        load_check("rst2_lwtop", 32'hFFE, 2'b10, 1'b0, 32'h0);
        load_check("rst2_lb40",  32'd40,  2'b00, 1'b1, 32'h0);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
